// File: rtl/circle_if.sv
// Handshake and pixel bus between a circle requester and the circle rasteriser.
interface circle_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int RW = 8
);
  logic          start;
  logic [2:0]    colour;
  logic [XW-1:0] centre_x;
  logic [YW-1:0] centre_y;
  logic [RW-1:0] radius;
  logic [7:0]    octant_mask;
  logic          fill;
  logic          busy;
  logic          done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;

  modport master (
    output start, colour, centre_x, centre_y, radius, octant_mask, fill,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, colour, centre_x, centre_y, radius, octant_mask, fill,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/circle_engine.sv
// Midpoint circle rasteriser: outline with per-octant mask, or filled disc
// drawn as horizontal spans. Emits one registered pixel request per clock.
module circle_engine #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int RW       = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic      clk,
  input logic      rst_n,
  circle_if.slave  bus
);

  // Working width wide enough that centre +/- radius never wraps.
  localparam int MXY = (XW > YW) ? XW : YW;
  localparam int CW  = ((MXY > RW) ? MXY : RW) + 3;
  localparam int KW  = RW + 3;

  localparam logic signed [CW-1:0] ZERO  = '0;
  localparam logic signed [CW-1:0] ONE   = CW'(1);
  localparam logic signed [CW-1:0] MAX_X = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] MAX_Y = CW'(SCREEN_H);

  typedef enum logic [2:0] {IDLE, INIT, OUTLINE, SPAN, DONE} state_t;

  state_t state;

  // Latched request
  logic signed [CW-1:0] cx, cy;
  logic [RW-1:0]        rad;
  logic [2:0]           col;
  logic [7:0]           mask;
  logic                 fill_mode;

  // Midpoint iteration state
  logic signed [CW-1:0] ox, oy, sx;
  logic signed [KW-1:0] crit;
  logic [2:0]           oct;
  logic [1:0]           span;
  logic                 drain;

  // Registered outputs
  logic          busy_r, done_r, plot_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [2:0]    colour_r;

  // Combinational step / pixel signals
  logic signed [CW-1:0] crit_w, oy_n, ox_n, crit_n;
  logic signed [CW-1:0] hw, sx_start, dx, dy, px, py;
  logic                 cont, span_end, iter_end, plot_en;

  // Pixel is visible only when both signed coordinates fall inside the screen.
  function automatic logic on_screen(input logic signed [CW-1:0] x,
                                     input logic signed [CW-1:0] y);
    return (x >= ZERO) && (x < MAX_X) && (y >= ZERO) && (y < MAX_Y);
  endfunction

  // Midpoint decision: next (ox, oy, crit) using the already-updated values.
  always_comb begin
    crit_w = CW'(crit);
    oy_n   = oy + ONE;
    if (crit_w <= ZERO) begin
      ox_n   = ox;
      crit_n = crit_w + (oy_n <<< 1) + ONE;
    end else begin
      ox_n   = ox - ONE;
      crit_n = crit_w + ((oy_n - ox_n) <<< 1) + ONE;
    end
    cont = (oy_n <= ox_n);
  end

  // Offset of the pixel emitted this cycle, for outline octants or fill spans.
  always_comb begin
    hw       = span[1] ? oy : ox;
    span_end = (sx == hw);
    sx_start = (span == 2'd0) ? -ox : -oy;
    iter_end = ((state == OUTLINE) && (oct == 3'd7)) ||
               ((state == SPAN) && (span == 2'd3) && span_end);
    dx = ZERO;
    dy = ZERO;
    if (state == SPAN) begin
      dx = sx;
      case (span)
        2'd0:    dy = oy;
        2'd1:    dy = -oy;
        2'd2:    dy = ox;
        default: dy = -ox;
      endcase
    end else begin
      case (oct)
        3'd0:    begin dx = ox;  dy = oy;  end
        3'd1:    begin dx = oy;  dy = ox;  end
        3'd2:    begin dx = -oy; dy = ox;  end
        3'd3:    begin dx = -ox; dy = oy;  end
        3'd4:    begin dx = -ox; dy = -oy; end
        3'd5:    begin dx = -oy; dy = -ox; end
        3'd6:    begin dx = oy;  dy = -ox; end
        default: begin dx = ox;  dy = -oy; end
      endcase
    end
    px      = cx + dx;
    py      = cy + dy;
    plot_en = on_screen(px, py) && (fill_mode || mask[oct]);
  end

  // Datapath: latch the request, then advance the midpoint and span counters.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.start) begin
          cx        <= CW'(bus.centre_x);
          cy        <= CW'(bus.centre_y);
          rad       <= bus.radius;
          col       <= bus.colour;
          mask      <= bus.octant_mask;
          fill_mode <= bus.fill;
        end
      end
      INIT: begin
        ox   <= CW'(rad);
        oy   <= ZERO;
        crit <= KW'(1) - KW'(rad);
        sx   <= ZERO - CW'(rad);
      end
      OUTLINE: begin
        if (!drain && iter_end) begin
          ox   <= ox_n;
          oy   <= oy_n;
          crit <= KW'(crit_n);
        end
      end
      SPAN: begin
        if (!drain) begin
          if (span_end) begin
            if (span == 2'd3) begin
              ox   <= ox_n;
              oy   <= oy_n;
              crit <= KW'(crit_n);
              sx   <= -ox_n;
            end else begin
              sx <= sx_start;
            end
          end else begin
            sx <= sx + ONE;
          end
        end
      end
      default: ;
    endcase
  end

  // Control FSM and registered pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      plot_r   <= 1'b0;
      x_r      <= '0;
      y_r      <= '0;
      colour_r <= '0;
      oct      <= '0;
      span     <= '0;
      drain    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            busy_r <= 1'b1;
            state  <= INIT;
          end
        end
        INIT: begin
          plot_r <= 1'b0;
          oct    <= '0;
          span   <= '0;
          drain  <= 1'b0;
          state  <= fill_mode ? SPAN : OUTLINE;
        end
        OUTLINE, SPAN: begin
          if (drain) begin
            // Last pixel of the final iteration has been presented.
            plot_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            drain  <= 1'b0;
            state  <= DONE;
          end else begin
            x_r      <= px[XW-1:0];
            y_r      <= py[YW-1:0];
            colour_r <= col;
            plot_r   <= plot_en;
            if (state == OUTLINE) begin
              oct <= oct + 3'd1;
            end else if (span_end) begin
              span <= span + 2'd1;
            end
            if (iter_end && !cont) begin
              drain <= 1'b1;
            end
          end
        end
        DONE: begin
          plot_r <= 1'b0;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (!bus.start) begin
            done_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.vga_plot   = plot_r;
  assign bus.vga_x      = x_r;
  assign bus.vga_y      = y_r;
  assign bus.vga_colour = colour_r;

endmodule

// File: tb/tb_circle_engine.sv
// Directed bench for circle_engine: outline, clipping, octant mask, fill,
// asynchronous reset mid-draw and start-held handshake.
module tb_circle_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  circle_if #(.XW(8), .YW(7), .RW(8)) bus ();

  circle_engine #(
    .XW(8), .YW(7), .RW(8), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int qx[$];
  int qy[$];
  bit qp[$];
  bit finished;
  int busy_bad;

  // Launch one draw and record every cycle from accept until done rises.
  task automatic draw(input int cx, input int cy, input int r,
                      input logic [7:0] m, input logic f, input bit hold);
    qx.delete(); qy.delete(); qp.delete();
    finished = 0;
    busy_bad = 0;
    @(negedge clk);
    bus.centre_x    = 8'(cx);
    bus.centre_y    = 7'(cy);
    bus.radius      = 8'(r);
    bus.octant_mask = m;
    bus.fill        = f;
    bus.colour      = 3'd5;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        finished = 1;
        break;
      end
      if (!bus.busy) busy_bad++;
      qx.push_back(int'(bus.vga_x));
      qy.push_back(int'(bus.vga_y));
      qp.push_back(bus.vga_plot);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.colour = '0; bus.centre_x = '0; bus.centre_y = '0;
    bus.radius = '0; bus.octant_mask = '0; bus.fill = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.vga_plot} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {bus.busy, bus.done, bus.vga_plot});
    end
    checks++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0) begin
      errors++; $display("FAIL reset_data got %h want 0", {bus.vga_x, bus.vga_y, bus.vga_colour});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.vga_plot} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b want 000", {bus.busy, bus.done, bus.vga_plot});
    end
  endtask

  task automatic test_radius_zero();
    int plots, badpos;
    draw(80, 60, 0, 8'hFF, 1'b0, 1'b0);
    plots = 0; badpos = 0;
    for (int i = 2; i < qp.size(); i++) begin
      if (qp[i]) begin
        plots++;
        if (qx[i] != 80 || qy[i] != 60) badpos++;
      end
    end
    checks++;
    if (!finished) begin errors++; $display("FAIL r0_timeout got not-done want done"); end
    checks++;
    if (qp.size() != 10) begin errors++; $display("FAIL r0_cycles got %0d want 10", qp.size()); end
    checks++;
    if (qp.size() < 2 || qp[0] !== 1'b0 || qp[1] !== 1'b0) begin
      errors++; $display("FAIL r0_latency first pixel not after two cycles");
    end
    checks++;
    if (plots != 8) begin errors++; $display("FAIL r0_plots got %0d want 8", plots); end
    checks++;
    if (badpos != 0) begin errors++; $display("FAIL r0_position got %0d off-centre want 0", badpos); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL r0_busy got %0d low cycles want 0", busy_bad); end
    checks++;
    if ({bus.done, bus.busy, bus.vga_plot} !== 3'b100) begin
      errors++; $display("FAIL r0_done_state got %b want 100", {bus.done, bus.busy, bus.vga_plot});
    end
  endtask

  task automatic check_r1(input string tag);
    int ex [16] = '{81, 80, 80, 79, 79, 80, 80, 81, 81, 81, 79, 79, 79, 79, 81, 81};
    int ey [16] = '{60, 61, 61, 60, 60, 59, 59, 60, 61, 61, 61, 61, 59, 59, 59, 59};
    draw(80, 60, 1, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (!finished || qp.size() != 18) begin
      errors++; $display("FAIL %s_cycles got %0d done=%0d want 18", tag, qp.size(), finished);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (qp[i+2] !== 1'b1 || qx[i+2] != ex[i] || qy[i+2] != ey[i]) begin
          errors++;
          $display("FAIL %s_pixel%0d got (%0d,%0d,p%0d) want (%0d,%0d,p1)",
                   tag, i, qx[i+2], qy[i+2], qp[i+2], ex[i], ey[i]);
        end
      end
    end
    checks++;
    if (bus.vga_colour !== 3'd5) begin
      errors++; $display("FAIL %s_colour got %0d want 5", tag, bus.vga_colour);
    end
  endtask

  task automatic test_radius_one();
    check_r1("r1");
  endtask

  task automatic test_clip();
    int plots, bad;
    draw(0, 0, 10, 8'hFF, 1'b0, 1'b0);
    plots = 0; bad = 0;
    for (int i = 2; i < qp.size(); i++) begin
      if (qp[i]) begin
        plots++;
        if (qx[i] > 10 || qy[i] > 10) bad++;
      end
    end
    checks++;
    if (!finished || qp.size() != 66) begin
      errors++; $display("FAIL clip_cycles got %0d want 66", qp.size());
    end
    checks++;
    if (plots != 18) begin errors++; $display("FAIL clip_plots got %0d want 18", plots); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clip_range got %0d out-of-quadrant want 0", bad); end
  endtask

  task automatic test_mask();
    int n_ff, p_ff, p_01, bad;
    draw(80, 60, 20, 8'hFF, 1'b0, 1'b0);
    n_ff = qp.size(); p_ff = 0;
    foreach (qp[i]) if (qp[i]) p_ff++;
    checks++;
    if (!finished || n_ff != 122) begin errors++; $display("FAIL maskff_cycles got %0d want 122", n_ff); end
    checks++;
    if (p_ff != 120) begin errors++; $display("FAIL maskff_plots got %0d want 120", p_ff); end
    draw(80, 60, 20, 8'h01, 1'b0, 1'b0);
    p_01 = 0; bad = 0;
    for (int i = 0; i < qp.size(); i++) begin
      if (qp[i]) begin
        p_01++;
        if (qx[i] < 80 || qy[i] < 60 || (qx[i] - 80) < (qy[i] - 60)) bad++;
      end
    end
    checks++;
    if (!finished || qp.size() != 122) begin errors++; $display("FAIL mask01_cycles got %0d want 122", qp.size()); end
    checks++;
    if (p_01 != 15) begin errors++; $display("FAIL mask01_plots got %0d want 15", p_01); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mask01_octant got %0d stray want 0", bad); end
  endtask

  task automatic test_fill();
    int plots, bad, dx, dy;
    logic [8:0] row;
    draw(80, 60, 2, 8'h00, 1'b1, 1'b0);
    plots = 0; bad = 0; row = '0;
    for (int i = 0; i < qp.size(); i++) begin
      if (qp[i]) begin
        plots++;
        dx = qx[i] - 80; dy = qy[i] - 60;
        if (dx * dx + dy * dy > 6) bad++;
        if (qy[i] == 60 && qx[i] >= 76 && qx[i] <= 84) row[qx[i] - 76] = 1'b1;
      end
    end
    checks++;
    if (!finished || qp.size() != 30) begin errors++; $display("FAIL fill_cycles got %0d want 30", qp.size()); end
    checks++;
    if (plots != 28) begin errors++; $display("FAIL fill_plots got %0d want 28", plots); end
    checks++;
    if (row !== 9'b001111100) begin errors++; $display("FAIL fill_row60 got %b want 001111100", row); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_radius got %0d outside want 0", bad); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.centre_x = 8'd80; bus.centre_y = 7'd60; bus.radius = 8'd20;
    bus.octant_mask = 8'hFF; bus.fill = 1'b0; bus.colour = 3'd3; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== 21'd0) begin
      errors++;
      $display("FAIL mid_async_reset got %h want 0",
               {bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour});
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_r1("redraw");
  endtask

  task automatic test_start_held();
    int held_bad;
    draw(80, 60, 0, 8'hFF, 1'b0, 1'b1);
    checks++;
    if (!finished) begin errors++; $display("FAIL hold_timeout got not-done want done"); end
    held_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) held_bad++;
    end
    checks++;
    if (held_bad != 0) begin errors++; $display("FAIL hold_no_restart got %0d bad cycles want 0", held_bad); end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_release_done got %b want 0", bus.done); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_idle_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_radius_zero();
    test_radius_one();
    test_clip();
    test_mask();
    test_fill();
    test_reset_mid();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
